// File: rtl/mmio_store_bridge.sv
// Data-side bridge for a single-cycle core: routes loads/stores between data RAM and a
// 256-byte peripheral window whose TXDATA stores are queued and drained over valid/ready.
module mmio_store_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'h0200_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic        per_valid,
  output logic [31:0] per_data,
  input  logic        per_ready,
  output logic        ovf_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  // Peripheral handshake: per_data is the FIFO head and is meaningful only while
  // per_valid=1; a word leaves on any rising edge where per_valid & per_ready, and the
  // head holds stable while per_valid=1 and per_ready=0.

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic        w_mmio_hit;
  logic [7:0]  w_offset;
  logic        w_empty;
  logic        w_full;
  logic        w_push_req;
  logic        w_pop;
  logic        w_flush;
  logic        w_ovf_clr;
  logic        w_push_acc;
  logic        w_pop_acc;
  logic        w_drop;
  logic [31:0] w_status;
  logic [31:0] w_reg_rdata;

  assign w_mmio_hit = (cpu_addr[31:8] == MMIO_BASE[31:8]);
  assign w_offset   = cpu_addr[7:0];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));

  assign w_push_req = cpu_we & w_mmio_hit & (w_offset == OFF_TXDATA);
  assign w_pop      = per_valid & per_ready;
  assign w_flush    = cpu_we & w_mmio_hit & (w_offset == OFF_CTRL) & cpu_wdata[1];
  assign w_ovf_clr  = cpu_we & w_mmio_hit & (w_offset == OFF_CTRL) & cpu_wdata[0];

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_pop_acc  = w_pop & ~w_flush;
  assign w_push_acc = w_push_req & ~w_flush & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_flush & w_full & ~w_pop;

  assign ram_we    = cpu_we & ~w_mmio_hit;
  assign per_valid = ~w_empty;
  assign per_data  = r_mem[r_rd_ptr];
  assign ovf_irq   = r_ovf;

  assign w_status = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};

  always_comb begin
    w_reg_rdata = 32'h0000_0000;
    if (w_offset == OFF_STATUS) begin
      w_reg_rdata = w_status;
    end
  end

  assign cpu_rdata = w_mmio_hit ? w_reg_rdata : ram_rdata;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear should both ever be requested together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_store_bridge.sv
// Bench for mmio_store_bridge: directed scenarios plus random traffic, all checked
// against a queue-based model of the peripheral FIFO and overflow flag.
module tb_mmio_store_bridge;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        per_valid;
  logic [31:0] per_data;
  logic        per_ready;
  logic        ovf_irq;

  mmio_store_bridge #(
    .MMIO_BASE (32'h0200_0000),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata),
    .per_valid(per_valid),
    .per_data (per_data),
    .per_ready(per_ready),
    .ovf_irq  (ovf_irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic        m_ovf;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] cnt;
    cnt = 8'(exp_q.size());
    return {16'h0000, cnt, 5'b00000, m_ovf, 1'(exp_q.size() == DEPTH), 1'(exp_q.size() == 0)};
  endfunction

  // driver
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ready);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    per_ready = ready;
    ram_rdata = $urandom;
  endtask

  // Checks all outputs mid-cycle, then advances one clock and updates the model.
  task automatic step();
    logic       hit;
    logic [7:0] off;
    logic       push, pop, flush, clr, full, drop;
    @(negedge clk);
    hit = (cpu_addr[31:8] == 24'h02_0000);
    off = cpu_addr[7:0];
    check("ram_we", ram_we, cpu_we & ~hit);
    check("cpu_rdata", cpu_rdata, hit ? ((off == 8'h04) ? m_status() : 32'h0) : ram_rdata);
    check("per_valid", per_valid, 1'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("per_data", per_data, exp_q[0]);
    check("ovf_irq", ovf_irq, m_ovf);
    push  = cpu_we && hit && off == 8'h00;
    flush = cpu_we && hit && off == 8'h08 && cpu_wdata[1];
    clr   = cpu_we && hit && off == 8'h08 && cpu_wdata[0];
    pop   = (exp_q.size() != 0) && per_ready;
    full  = (exp_q.size() == DEPTH);
    drop  = 1'b0;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (!full || pop) exp_q.push_back(cpu_wdata);
        else drop = 1'b1;
      end
    end
    if (clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic ready);
    drive(1'b1, 32'h0200_0000, w, ready);
    step();
  endtask

  task automatic idle(input logic ready);
    drive(1'b0, 32'h0000_0040, 32'h0, ready);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    drive(1'b0, 32'h0200_0004, 32'h0, 1'b0);
    #1;
    check("rst_status", cpu_rdata, 32'h0000_0001);
    check("rst_valid", per_valid, 1'b0);
    check("rst_ovf", ovf_irq, 1'b0);
    step();

    // RAM store then first MMIO push
    drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    #1 check("ram_store_we", ram_we, 1'b1);
    step();
    check("ram_store_fifo", per_valid, 1'b0);
    drive(1'b1, 32'h0200_0000, 32'h11, 1'b0);
    #1 check("mmio_store_we", ram_we, 1'b0);
    check("no_bypass", per_valid, 1'b0);
    step();
    idle(1'b0);
    #1;
    check("first_valid", per_valid, 1'b1);
    check("first_data", per_data, 32'h11);
    drive(1'b1, 32'h0200_0008, 32'h3, 1'b0);
    step();

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) push_word(32'(i), 1'b0);
    drive(1'b0, 32'h0200_0004, 32'h0, 1'b0);
    #1 check("full_status", cpu_rdata, 32'h0000_0802);
    step();
    push_word(32'd9, 1'b0);
    check("ovf_set", ovf_irq, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      idle(1'b1);
      #1 check("drain_data", per_data, 32'(i));
      step();
    end
    check("drain_empty", per_valid, 1'b0);
    drive(1'b1, 32'h0200_0008, 32'h1, 1'b0);
    step();
    check("ovf_clr", ovf_irq, 1'b0);

    // push into a full FIFO with a simultaneous pop
    for (int i = 1; i <= 8; i++) push_word(32'h100 + 32'(i), 1'b0);
    push_word(32'hAA, 1'b1);
    drive(1'b0, 32'h0200_0004, 32'h0, 1'b0);
    #1 check("pushpop_status", cpu_rdata, 32'h0000_0802);
    step();
    for (int i = 2; i <= 9; i++) begin
      idle(1'b1);
      #1 check("pushpop_order", per_data, (i == 9) ? 32'hAA : 32'h100 + 32'(i));
      step();
    end
    check("pushpop_empty", per_valid, 1'b0);

    // flush + overflow clear
    for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i), 1'b0);
    drive(1'b1, 32'h0200_0008, 32'h3, 1'b1);
    step();
    drive(1'b0, 32'h0200_0004, 32'h0, 1'b0);
    #1 check("flush_status", cpu_rdata, 32'h0000_0001);
    step();
    drive(1'b0, 32'h0200_000C, 32'h0, 1'b0);
    #1 check("unmapped_rd", cpu_rdata, 32'h0);
    step();

    // asynchronous reset mid-transfer
    for (int i = 0; i < 5; i++) push_word(32'h500 + 32'(i), 1'b0);
    drive(1'b0, 32'h0200_0004, 32'h0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", per_valid, 1'b0);
    check("arst_status", cpu_rdata, 32'h0000_0001);
    exp_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    push_word(32'h77, 1'b0);
    idle(1'b0);
    #1 check("post_rst_data", per_data, 32'h77);
    step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a, d;
      int sel;
      sel = $urandom_range(0, 9);
      d   = $urandom;
      case (sel)
        0, 1:    a = $urandom & 32'h00FF_FFFC;
        2, 3, 4: a = 32'h0200_0000;
        5, 6:    a = 32'h0200_0004;
        7: begin
          a = 32'h0200_0008;
          d = {30'h0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
        end
        8:       a = 32'h0200_0000 | 32'($urandom_range(9, 255));
        default: a = 32'h0201_0000;
      endcase
      drive(1'($urandom_range(0, 3) != 0), a, d, 1'($urandom_range(0, 2) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
